// File: rtl/counter_pkg.sv
// Shared definitions for the parametrised up/down modulus counter family.
// Mode constants, width limit and the load clamp helper.
package counter_pkg;

    localparam int unsigned CNT_WRAP      = 0;
    localparam int unsigned CNT_SAT       = 1;
    localparam int unsigned CNT_MAX_WIDTH = 32;

    // A load value outside the count range is pulled down to the top of the range.
    function automatic logic [CNT_MAX_WIDTH-1:0] clamp_load(
        input logic [CNT_MAX_WIDTH-1:0] val,
        input longint unsigned          modulus
    );
        if (64'(val) >= modulus) begin
            return CNT_MAX_WIDTH'(modulus - 64'd1);
        end
        return val;
    endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-count logic for one enabled step in either direction.
// Also reports whether the step crosses a range boundary.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up_dn,
    output logic [WIDTH-1:0] next_count,
    output logic             at_boundary
);

    localparam logic [WIDTH-1:0] MaxCnt = WIDTH'(MODULUS - 64'd1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] inc;
    logic [WIDTH:0] dec;
    logic           at_top;
    logic           at_bottom;

    assign cnt_ext = {1'b0, count};
    assign inc     = cnt_ext + (WIDTH+1)'(1);
    assign dec     = cnt_ext - (WIDTH+1)'(1);

    // The carry only fires for a full-range modulus, where it coincides with the compare.
    assign at_top    = (count == MaxCnt) | inc[WIDTH];
    assign at_bottom = dec[WIDTH];

    always_comb begin
        next_count  = up_dn ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
        at_boundary = up_dn ? at_top : at_bottom;
        if (at_boundary) begin
            if (SATURATE == CNT_SAT) begin
                next_count = count;
            end else begin
                next_count = up_dn ? '0 : MaxCnt;
            end
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// General-purpose up/down counter with programmable modulus, load, wrap/saturate mode,
// terminal-count flag, registered wrap pulse and sticky overflow flag.
module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : gen_bad_width
        $error("counter_mod_updown: WIDTH must be 1..%0d", CNT_MAX_WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : gen_bad_modulus
        $error("counter_mod_updown: MODULUS must be 2..2**WIDTH");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : gen_bad_mode
        $error("counter_mod_updown: SATURATE must be 0 or 1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_count;
    logic             at_boundary;
    logic             boundary_step;

    counter_next_val #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next_val (
        .count       (count_q),
        .up_dn       (up_dn),
        .next_count  (step_count),
        .at_boundary (at_boundary)
    );

    // A load suppresses the step, so it also suppresses wrap and the ovf set.
    assign boundary_step = en & ~load & at_boundary;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = (ovf_q & ~clr_ovf) | boundary_step;
        if (load) begin
            count_d = WIDTH'(clamp_load(CNT_MAX_WIDTH'(load_val), MODULUS));
        end else if (en) begin
            count_d = step_count;
            wrap_d  = at_boundary;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = at_boundary;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Scoreboard bench: a wrapping and a saturating counter (WIDTH=4, MODULUS=10) share stimulus
// and are checked against an arithmetic reference model every cycle.
module tb_counter_mod_updown;

    localparam int M = 10;

    typedef struct {
        int cnt [2];
        bit wrp [2];
        bit ov  [2];
        bit tc  [2];
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       clr_ovf = 1'b0;

    logic [3:0] cnt_w, cnt_s;
    logic       tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

    exp_t exp_q[$];
    int   m_cnt [2];
    bit   m_ovf [2];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    counter_mod_updown #(.WIDTH(4), .MODULUS(M), .SATURATE(0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .count(cnt_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
    );

    counter_mod_updown #(.WIDTH(4), .MODULUS(M), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .count(cnt_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    task automatic chk(input string name, input int s, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL cycle %0d %s sat=%0d: got %0d expected %0d", cyc, name, s, got, want);
        end
    endtask

    // Drive one cycle of inputs and push the post-edge expectation.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int v,
                        input bit c);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; up_dn = u; load = l; load_val = 4'(v); clr_ovf = c;
        for (int s = 0; s < 2; s++) begin
            bit bnd = 1'b0;
            if (r) begin
                m_cnt[s] = 0;
                m_ovf[s] = 1'b0;
            end else if (l) begin
                m_cnt[s] = (v > M - 1) ? M - 1 : v;
                m_ovf[s] = m_ovf[s] & ~c;
            end else begin
                if (e && u) begin
                    bnd = (m_cnt[s] == M - 1);
                    m_cnt[s] = (s == 1) ? ((m_cnt[s] + 1 > M - 1) ? M - 1 : m_cnt[s] + 1)
                                        : (m_cnt[s] + 1) % M;
                end else if (e) begin
                    bnd = (m_cnt[s] == 0);
                    m_cnt[s] = (s == 1) ? ((m_cnt[s] == 0) ? 0 : m_cnt[s] - 1)
                                        : (m_cnt[s] + M - 1) % M;
                end
                m_ovf[s] = (m_ovf[s] & ~c) | bnd;
            end
            x.cnt[s] = m_cnt[s];
            x.wrp[s] = bnd;
            x.ov[s]  = m_ovf[s];
            x.tc[s]  = (u && m_cnt[s] == M - 1) || (!u && m_cnt[s] == 0);
        end
        exp_q.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle, sampled just after the active edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                chk("count", 0, int'(cnt_w), x.cnt[0]);
                chk("wrap", 0, int'(wrap_w), int'(x.wrp[0]));
                chk("ovf", 0, int'(ovf_w), int'(x.ov[0]));
                chk("tc", 0, int'(tc_w), int'(x.tc[0]));
                chk("count", 1, int'(cnt_s), x.cnt[1]);
                chk("wrap", 1, int'(wrap_s), int'(x.wrp[1]));
                chk("ovf", 1, int'(ovf_s), int'(x.ov[1]));
                chk("tc", 1, int'(tc_s), int'(x.tc[1]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with up_dn=0: tc must be high at count 0.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // Count up through the 9 -> 0 wrap.
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0);
        // Load 2 and count down through 0 -> 9.
        step(0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
        // Load 8 and count up into the top end.
        step(0, 0, 1, 1, 8, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0, 0);
        // Out-of-range load with en in the same cycle.
        step(0, 1, 1, 1, 15, 0);
        // clr_ovf coincident with a boundary step, then on a quiet cycle.
        step(0, 1, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        // Reset mid-count with en and load also asserted.
        step(0, 0, 1, 1, 6, 0);
        step(1, 1, 1, 1, 3, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 11) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 0, exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_mod_updown.md
Name: counter_mod_updown

Overview:
- Parametrised successor to the team's fixed-width free-running counters.
- Adds the following:
  - a programmable width and modulus,
  - up/down direction,
  - count enable,
  - synchronous parallel load,
  - wrap or saturate mode,
  - a terminal-count flag,
  - a registered wrap pulse,
  - a sticky overflow flag.
- Intended as the general-purpose counter for timers, address generators and event counters across the design.

Parameters:
WIDTH, 8, bit width of count and load_val (1..32)
MODULUS, 256, count range is 0..MODULUS-1; legal range 2..2**WIDTH
SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  count enable; one step per cycle while high
up_dn  input  1  1 = increment, 0 = decrement; sampled only when en=1
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value loaded when load=1
clr_ovf  input  1  clears the sticky overflow flag
count  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational from registered state)
wrap  output  1  one-cycle pulse (registered), boundary crossing
ovf  output  1  sticky flag (registered), set on any boundary crossing

Behaviour:
- One clock (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: count=0, wrap=0, ovf=0. tc follows the state (1 after reset if up_dn=0, since count=0 is the down terminal).
- Priority per cycle: reset > load > en > hold.
- Load:
  - count <= load_val.
  - If load_val >= MODULUS, count <= MODULUS-1 (clamped).
  - wrap <= 0; ovf is unaffected.
  - Load overrides en in the same cycle.
- Enable, up (up_dn=1):
  - If count < MODULUS-1: count <= count+1.
  - If count == MODULUS-1:
    - SATURATE=0: count <= 0, wrap <= 1, ovf <= 1.
    - SATURATE=1: count holds, wrap <= 1, ovf <= 1.
- Enable, down (up_dn=0):
  - If count > 0: count <= count-1.
  - If count == 0:
    - SATURATE=0: count <= MODULUS-1, wrap <= 1, ovf <= 1.
    - SATURATE=1: count holds, wrap <= 1, ovf <= 1.
- wrap:
  - 0 in every cycle that is not a boundary step.
  - High for exactly one cycle per boundary event.
  - Asserts on every cycle en stays high at a saturated end.
- tc:
  - = (up_dn & count==MODULUS-1) | (~up_dn & count==0).
  - Independent of en.
  - Zero-latency view of the next boundary step.
- ovf:
  - Set on any boundary step.
  - Cleared by clr_ovf.
  - If clr_ovf and a boundary step occur in the same cycle, set wins (ovf=1).
- Latency: count changes on the edge following the cycle in which en/load is sampled.
- Arithmetic: next-value logic is computed at WIDTH+1 bits internally. With MODULUS = 2**WIDTH, the wrap falls on the natural rollover and must match the explicit compare.
- Reset asserted mid-count: all state returns to reset values on that edge, regardless of en/load.
- Direction change mid-run takes effect on the next enabled edge; there is no extra state.
- Parameter check: out-of-range MODULUS or WIDTH is an elaboration-time error (generate-time assertion).

Decomposition:
- Shared package counter_pkg:
  - mode constants CNT_WRAP=0 and CNT_SAT=1 for SATURATE,
  - a function that computes the clamped load value,
  - a max-width constant CNT_MAX_WIDTH=32.
- One natural sub-module, counter_next_val, combinational. It takes count, up_dn, MODULUS and SATURATE, and produces next_count and at_boundary.
- The top level holds registers, priority logic, wrap and ovf.

Test Plan:
- Reset then en=1, up_dn=1, WIDTH=4, MODULUS=10, SATURATE=0, for 12 cycles:
  - count sequence 1..9, 0, 1, 2;
  - wrap high only on the cycle count goes 9→0;
  - tc=1 while count=9;
  - ovf=1 from that point on.
- Same configuration, down from load_val=2, en=1, up_dn=0:
  - count 1, 0, 9, 8;
  - wrap pulses on 0→9.
- SATURATE=1, MODULUS=10, load 8, count up 4 cycles:
  - count 9, 9, 9, 9;
  - wrap high on cycles 2-4;
  - count never wraps.
- load=1 with load_val=15, MODULUS=10, en=1, same cycle:
  - count=9 (clamped);
  - no increment that cycle;
  - wrap=0.
- ovf set, then clr_ovf=1 on the same edge as a 9→0 wrap:
  - ovf stays 1.
  - clr_ovf on the next non-boundary cycle gives ovf=0.
- reset=1 asserted mid-count at count=6 with en=1 and load=1:
  - next edge gives count=0, wrap=0, ovf=0.
  - Counting resumes at 1 the cycle after reset deasserts.
